// File: rtl/layer_sched_pkg.sv
// rtl/layer_sched_pkg.sv - shared state encoding, loop codes and loop-order helpers for layer_sched
package layer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } sched_state_t;

    localparam logic [1:0] LOOP_PAT    = 2'd0;
    localparam logic [1:0] LOOP_FTRGRP = 2'd1;
    localparam logic [1:0] LOOP_BLK    = 2'd2;

    // Outer patch, middle filter group, inner block.
    localparam logic [5:0] LOOP_PTY_DEFAULT = {LOOP_PAT, LOOP_FTRGRP, LOOP_BLK};

    // Three distinct codes, none of them 3, is exactly a permutation of {0,1,2}.
    function automatic logic loop_pty_legal(input logic [5:0] pty);
        logic [1:0] c_out;
        logic [1:0] c_mid;
        logic [1:0] c_in;
        c_out = pty[5:4];
        c_mid = pty[3:2];
        c_in  = pty[1:0];
        return (c_out != 2'd3) && (c_mid != 2'd3) && (c_in != 2'd3) &&
               (c_out != c_mid) && (c_out != c_in) && (c_mid != c_in);
    endfunction

    function automatic logic sel3(input logic [1:0] code, input logic a, input logic b, input logic c);
        case (code)
            LOOP_PAT:    return a;
            LOOP_FTRGRP: return b;
            default:     return c;
        endcase
    endfunction

    // Increment condition for the loop with the given code, from the slot it occupies.
    function automatic logic loop_inc(input logic [1:0] code, input logic [1:0] code_in,
                                      input logic [1:0] code_mid, input logic w_in, input logic w_mid);
        if (code == code_in)
            return 1'b1;
        else if (code == code_mid)
            return w_in;
        else
            return w_in & w_mid;
    endfunction

endpackage

// File: rtl/layer_sched_wrap_cnt.sv
// rtl/layer_sched_wrap_cnt.sv - wrapping loop counter with clear, increment, wrap flag and carry-out
module sched_wrap_cnt
    import layer_sched_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         carry
);

    assign wrap  = (cnt == max);
    assign carry = inc & wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - per-layer loop-nest sequencer issuing tile commands to the PE array
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int FRAME_WIDTH  = 6,
    parameter int PATCH_WIDTH  = 8,
    parameter int FTRGRP_WIDTH = 6,
    parameter int BLK_WIDTH    = 6,
    parameter int LAYER_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CFGIF_rdy,
    input  logic [5:0]              CFG_LoopPty,
    input  logic [FRAME_WIDTH-1:0]  CFG_NumFrm,
    input  logic [PATCH_WIDTH-1:0]  CFG_NumPat,
    input  logic [FTRGRP_WIDTH-1:0] CFG_NumFtrGrp,
    input  logic [BLK_WIDTH-1:0]    CFG_NumBlk,
    input  logic [LAYER_WIDTH-1:0]  CFG_NumLay,
    output logic                    Rst_Layer,
    output logic                    SCH_val,
    input  logic                    PESCH_rdy,
    input  logic                    PESCH_done,
    output logic [FRAME_WIDTH-1:0]  SCH_Frm,
    output logic [PATCH_WIDTH-1:0]  SCH_Pat,
    output logic [FTRGRP_WIDTH-1:0] SCH_FtrGrp,
    output logic [BLK_WIDTH-1:0]    SCH_Blk,
    output logic [LAYER_WIDTH-1:0]  SCH_Lay,
    output logic                    SCH_First,
    output logic                    SCH_Last,
    output logic                    SCH_Busy,
    output logic                    SCH_AllDone,
    output logic                    SCH_CfgErr
);

    sched_state_t            state;
    logic [5:0]              pty_q;
    logic [FRAME_WIDTH-1:0]  max_frm;
    logic [PATCH_WIDTH-1:0]  max_pat;
    logic [FTRGRP_WIDTH-1:0] max_ftr;
    logic [BLK_WIDTH-1:0]    max_blk;
    logic [LAYER_WIDTH-1:0]  num_lay_q;

    logic clr_cnt, adv;
    logic wrap_frm, wrap_pat, wrap_ftr, wrap_blk;
    logic carry_frm, carry_pat, carry_ftr, carry_blk;
    logic inc_frm, inc_pat, inc_ftr, inc_blk;
    logic w_in, w_mid, layer_end;

    assign clr_cnt = (state == ST_LOAD);
    assign adv     = (state == ST_WAIT) && PESCH_done;

    // Carry chain is steered by the latched order; wraps are registered compares, so no loop.
    assign w_in    = sel3(pty_q[1:0], wrap_pat, wrap_ftr, wrap_blk);
    assign w_mid   = sel3(pty_q[3:2], wrap_pat, wrap_ftr, wrap_blk);
    assign inc_pat = adv & loop_inc(LOOP_PAT,    pty_q[1:0], pty_q[3:2], w_in, w_mid);
    assign inc_ftr = adv & loop_inc(LOOP_FTRGRP, pty_q[1:0], pty_q[3:2], w_in, w_mid);
    assign inc_blk = adv & loop_inc(LOOP_BLK,    pty_q[1:0], pty_q[3:2], w_in, w_mid);
    assign inc_frm = sel3(pty_q[5:4], carry_pat, carry_ftr, carry_blk);

    // Frame carry-out fires only when the finished tile was the last of the layer.
    assign layer_end = carry_frm;

    assign SCH_First = SCH_val && (SCH_Frm == '0) && (SCH_Pat == '0) &&
                       (SCH_FtrGrp == '0) && (SCH_Blk == '0);
    assign SCH_Last  = SCH_val & wrap_frm & wrap_pat & wrap_ftr & wrap_blk;

    sched_wrap_cnt #(.W(FRAME_WIDTH)) u_cnt_frm (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_frm), .max(max_frm),
        .cnt(SCH_Frm), .wrap(wrap_frm), .carry(carry_frm)
    );
    sched_wrap_cnt #(.W(PATCH_WIDTH)) u_cnt_pat (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_pat), .max(max_pat),
        .cnt(SCH_Pat), .wrap(wrap_pat), .carry(carry_pat)
    );
    sched_wrap_cnt #(.W(FTRGRP_WIDTH)) u_cnt_ftr (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_ftr), .max(max_ftr),
        .cnt(SCH_FtrGrp), .wrap(wrap_ftr), .carry(carry_ftr)
    );
    sched_wrap_cnt #(.W(BLK_WIDTH)) u_cnt_blk (
        .clk(clk), .rst(rst), .clr(clr_cnt), .inc(inc_blk), .max(max_blk),
        .cnt(SCH_Blk), .wrap(wrap_blk), .carry(carry_blk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pty_q       <= LOOP_PTY_DEFAULT;
            max_frm     <= '0;
            max_pat     <= '0;
            max_ftr     <= '0;
            max_blk     <= '0;
            num_lay_q   <= '0;
            SCH_val     <= 1'b0;
            Rst_Layer   <= 1'b0;
            SCH_AllDone <= 1'b0;
            SCH_Busy    <= 1'b0;
            SCH_CfgErr  <= 1'b0;
            SCH_Lay     <= '0;
        end else begin
            Rst_Layer   <= 1'b0;
            SCH_AllDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CFGIF_rdy) begin
                        state    <= ST_LOAD;
                        SCH_Busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    max_frm   <= CFG_NumFrm;
                    max_pat   <= CFG_NumPat;
                    max_ftr   <= CFG_NumFtrGrp;
                    max_blk   <= CFG_NumBlk;
                    num_lay_q <= CFG_NumLay;
                    if (loop_pty_legal(CFG_LoopPty)) begin
                        pty_q <= CFG_LoopPty;
                    end else begin
                        pty_q      <= LOOP_PTY_DEFAULT;
                        SCH_CfgErr <= 1'b1;
                    end
                    SCH_val <= 1'b1;
                    state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (PESCH_rdy) begin
                        SCH_val <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (PESCH_done) begin
                        if (layer_end) begin
                            Rst_Layer   <= 1'b1;
                            SCH_AllDone <= (SCH_Lay == num_lay_q);
                            state       <= ST_DONE;
                        end else begin
                            SCH_val <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    SCH_Lay  <= (SCH_Lay == num_lay_q) ? '0 : SCH_Lay + 1'b1;
                    SCH_Busy <= 1'b0;
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - directed self-checking bench for layer_sched
module tb_layer_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       CFGIF_rdy;
    logic [5:0] CFG_LoopPty;
    logic [5:0] CFG_NumFrm;
    logic [7:0] CFG_NumPat;
    logic [5:0] CFG_NumFtrGrp;
    logic [5:0] CFG_NumBlk;
    logic [4:0] CFG_NumLay;
    logic       Rst_Layer;
    logic       SCH_val;
    logic       PESCH_rdy;
    logic       PESCH_done;
    logic [5:0] SCH_Frm;
    logic [7:0] SCH_Pat;
    logic [5:0] SCH_FtrGrp;
    logic [5:0] SCH_Blk;
    logic [4:0] SCH_Lay;
    logic       SCH_First;
    logic       SCH_Last;
    logic       SCH_Busy;
    logic       SCH_AllDone;
    logic       SCH_CfgErr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rst_cnt     = 0;
    int rst_cyc[$];

    layer_sched #(
        .FRAME_WIDTH(6), .PATCH_WIDTH(8), .FTRGRP_WIDTH(6), .BLK_WIDTH(6), .LAYER_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst), .CFGIF_rdy(CFGIF_rdy), .CFG_LoopPty(CFG_LoopPty),
        .CFG_NumFrm(CFG_NumFrm), .CFG_NumPat(CFG_NumPat), .CFG_NumFtrGrp(CFG_NumFtrGrp),
        .CFG_NumBlk(CFG_NumBlk), .CFG_NumLay(CFG_NumLay), .Rst_Layer(Rst_Layer),
        .SCH_val(SCH_val), .PESCH_rdy(PESCH_rdy), .PESCH_done(PESCH_done),
        .SCH_Frm(SCH_Frm), .SCH_Pat(SCH_Pat), .SCH_FtrGrp(SCH_FtrGrp), .SCH_Blk(SCH_Blk),
        .SCH_Lay(SCH_Lay), .SCH_First(SCH_First), .SCH_Last(SCH_Last), .SCH_Busy(SCH_Busy),
        .SCH_AllDone(SCH_AllDone), .SCH_CfgErr(SCH_CfgErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Rst_Layer === 1'b1) begin
            rst_cnt <= rst_cnt + 1;
            rst_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_layer(input logic [5:0] pty, input int frm, input int pat,
                               input int ftr, input int blk, input int nlay);
        CFG_LoopPty   = pty;
        CFG_NumFrm    = 6'(frm);
        CFG_NumPat    = 8'(pat);
        CFG_NumFtrGrp = 6'(ftr);
        CFG_NumBlk    = 6'(blk);
        CFG_NumLay    = 5'(nlay);
        CFGIF_rdy     = 1'b1;
    endtask

    task automatic wait_val(input string tag);
        int n = 0;
        while (SCH_val !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_val"}, 32'(SCH_val), 32'd1);
    endtask

    // Expects PESCH_rdy high; accepts the tile then returns done one cycle later.
    task automatic serve_tile(input string tag, input int frm, input int pat, input int ftr,
                              input int blk, input bit first, input bit last, input int lay);
        wait_val(tag);
        chk({tag, "_frm"}, 32'(SCH_Frm), 32'(frm));
        chk({tag, "_pat"}, 32'(SCH_Pat), 32'(pat));
        chk({tag, "_ftr"}, 32'(SCH_FtrGrp), 32'(ftr));
        chk({tag, "_blk"}, 32'(SCH_Blk), 32'(blk));
        chk({tag, "_first"}, 32'(SCH_First), 32'(first));
        chk({tag, "_last"}, 32'(SCH_Last), 32'(last));
        chk({tag, "_lay"}, 32'(SCH_Lay), 32'(lay));
        tick();
        chk({tag, "_acc"}, 32'(SCH_val), 32'd0);
        PESCH_done = 1'b1;
        tick();
        PESCH_done = 1'b0;
    endtask

    task automatic finish_layer(input string tag, input bit exp_all, input bit keep_rdy);
        chk({tag, "_rstlay"}, 32'(Rst_Layer), 32'd1);
        chk({tag, "_alldone"}, 32'(SCH_AllDone), 32'(exp_all));
        chk({tag, "_busy_done"}, 32'(SCH_Busy), 32'd1);
        if (!keep_rdy) CFGIF_rdy = 1'b0;
        tick();
        chk({tag, "_rstlay_gap"}, 32'(Rst_Layer), 32'd0);
        chk({tag, "_busy_gap"}, 32'(SCH_Busy), 32'd0);
        tick();
    endtask

    // Counts Pat=1, FtrGrp=1, Blk=2 walked as pat outer, ftrgrp middle, blk inner.
    task automatic run_pfb_layer(input string tag, input logic [5:0] pty);
        int idx;
        start_layer(pty, 0, 1, 1, 2, 0);
        tick();
        chk({tag, "_load_val"}, 32'(SCH_val), 32'd0);
        chk({tag, "_load_busy"}, 32'(SCH_Busy), 32'd1);
        tick();
        chk({tag, "_issue_val"}, 32'(SCH_val), 32'd1);
        idx = 0;
        for (int p = 0; p < 2; p++)
            for (int f = 0; f < 2; f++)
                for (int b = 0; b < 3; b++) begin
                    serve_tile($sformatf("%s_t%0d", tag, idx), 0, p, f, b, idx == 0, idx == 11, 0);
                    idx++;
                end
        finish_layer(tag, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        CFGIF_rdy  = 1'b0;
        PESCH_rdy  = 1'b1;
        PESCH_done = 1'b0;
        start_layer(6'b00_01_10, 0, 0, 0, 0, 0);
        CFGIF_rdy  = 1'b0;
        tick();
        tick();
        chk("reset_ctl", 32'({SCH_val, Rst_Layer, SCH_Busy, SCH_AllDone, SCH_CfgErr, SCH_First, SCH_Last}), 32'd0);
        chk("reset_idx", 32'({SCH_Frm, SCH_Pat, SCH_FtrGrp, SCH_Blk, SCH_Lay}), 32'd0);
        rst = 1'b0;
        tick();

        run_pfb_layer("order", 6'b00_01_10);
        chk("order_rstcnt", 32'(rst_cnt), 32'd1);
        chk("order_cfgerr", 32'(SCH_CfgErr), 32'd0);

        start_layer(6'b00_01_10, 0, 0, 0, 1, 0);
        PESCH_rdy = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_val%0d", i), 32'(SCH_val), 32'd1);
            chk($sformatf("bp_blk%0d", i), 32'(SCH_Blk), 32'd0);
            chk($sformatf("bp_first%0d", i), 32'(SCH_First), 32'd1);
            tick();
        end
        chk("bp_val_hold", 32'(SCH_val), 32'd1);
        PESCH_rdy = 1'b1;
        tick();
        chk("bp_accept", 32'(SCH_val), 32'd0);
        PESCH_done = 1'b1;
        tick();
        PESCH_done = 1'b0;
        serve_tile("bp_t1", 0, 0, 0, 1, 1'b0, 1'b1, 0);
        finish_layer("bp", 1'b1, 1'b0);

        run_pfb_layer("illegal", 6'b01_01_10);
        chk("illegal_cfgerr", 32'(SCH_CfgErr), 32'd1);

        base = rst_cnt;
        start_layer(6'b00_01_10, 0, 0, 0, 0, 2);
        for (int l = 0; l < 3; l++) begin
            serve_tile($sformatf("ml_l%0d", l), 0, 0, 0, 0, 1'b1, 1'b1, l);
            finish_layer($sformatf("ml_l%0d", l), l == 2, l != 2);
        end
        chk("ml_lay_wrap", 32'(SCH_Lay), 32'd0);
        chk("ml_rstcnt", 32'(rst_cnt - base), 32'd3);
        if (rst_cnt - base == 3) begin
            chk("ml_gap01", 32'(rst_cyc[base + 1] - rst_cyc[base] >= 4), 32'd1);
            chk("ml_gap12", 32'(rst_cyc[base + 2] - rst_cyc[base + 1] >= 4), 32'd1);
        end

        start_layer(6'b00_01_10, 1, 0, 0, 0, 0);
        serve_tile("frm_t0", 0, 0, 0, 0, 1'b1, 1'b0, 0);
        serve_tile("frm_t1", 1, 0, 0, 0, 1'b0, 1'b1, 0);
        finish_layer("frm", 1'b1, 1'b0);

        start_layer(6'b00_01_10, 0, 1, 0, 0, 0);
        wait_val("stray");
        PESCH_rdy  = 1'b0;
        PESCH_done = 1'b1;
        tick();
        PESCH_done = 1'b0;
        chk("stray_val", 32'(SCH_val), 32'd1);
        chk("stray_pat", 32'(SCH_Pat), 32'd0);
        PESCH_rdy = 1'b1;
        tick();
        chk("wait_val", 32'(SCH_val), 32'd0);
        chk("wait_busy", 32'(SCH_Busy), 32'd1);
        chk("wait_cfgerr", 32'(SCH_CfgErr), 32'd1);
        base = rst_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ctl", 32'({SCH_val, Rst_Layer, SCH_Busy, SCH_AllDone, SCH_CfgErr, SCH_First, SCH_Last}), 32'd0);
        chk("midrst_idx", 32'({SCH_Frm, SCH_Pat, SCH_FtrGrp, SCH_Blk, SCH_Lay}), 32'd0);
        CFGIF_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_no_pop", 32'(rst_cnt - base), 32'd0);
        chk("midrst_idle", 32'(SCH_Busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
